crossbar_arbiter_qos: RTL and testbench

CROSSBAR_ARBITER_QOS -- requirements
Module: crossbar_arbiter_qos

---
 rtl/crossbar_arbiter_qos.sv | 141 ++++++++++++++
 tb/tb_crossbar_arbiter_qos.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/crossbar_arbiter_qos.sv
// QoS crossbar arbiter: per-output priority + round-robin selection with
// transaction locking, starvation promotion and a side priority channel.
module crossbar_arbiter_qos #(
    parameter  int N_IN_PORTS    = 8,
    parameter  int N_OUT_PORTS   = 8,
    parameter  int N_PRIO_LEVELS = 4,
    parameter  int STARVE_LIMIT  = 15,
    localparam int PW = (N_PRIO_LEVELS > 1) ? $clog2(N_PRIO_LEVELS) : 1,
    localparam int AW = $clog2(STARVE_LIMIT + 1),
    localparam int OW = (N_OUT_PORTS > 1) ? $clog2(N_OUT_PORTS) : 1,
    localparam int IW = (N_IN_PORTS > 1) ? $clog2(N_IN_PORTS) : 1,
    localparam int LW = $clog2(N_PRIO_LEVELS + 1)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_IN_PORTS-1:0]                  req,
    input  logic [N_IN_PORTS-1:0][OW-1:0]          req_out_port,
    input  logic [N_IN_PORTS-1:0][PW-1:0]          req_prio,
    input  logic [N_IN_PORTS-1:0]                  req_last,
    input  logic [N_OUT_PORTS-1:0]                 out_ready,
    input  logic [N_OUT_PORTS-1:0]                 priority_req,
    output logic [N_OUT_PORTS-1:0]                 priority_grant,
    output logic [N_IN_PORTS-1:0]                  grant,
    output logic [N_OUT_PORTS-1:0][N_IN_PORTS-1:0] detailed_grant,
    output logic [N_OUT_PORTS-1:0][IW-1:0]         granted_requester_id,
    output logic [N_OUT_PORTS-1:0]                 locked,
    output logic [N_IN_PORTS-1:0]                  starved
);

    // Handshake: a beat moves on output o in the cycle detailed_grant[o][i]
    // is high; that needs req[i], out_ready[o] and no side request on o.

    logic [N_OUT_PORTS-1:0]                 r_lock;
    logic [N_OUT_PORTS-1:0][IW-1:0]         r_owner;
    logic [N_OUT_PORTS-1:0][IW-1:0]         r_rr_ptr;
    logic [N_IN_PORTS-1:0][AW-1:0]          r_age;

    logic [N_IN_PORTS-1:0]                  w_starved;
    logic [N_IN_PORTS-1:0][LW-1:0]          w_level;
    logic [N_OUT_PORTS-1:0][N_IN_PORTS-1:0] w_cand;
    logic [N_OUT_PORTS-1:0][LW-1:0]         w_max;
    logic [N_OUT_PORTS-1:0]                 w_found;
    logic [N_OUT_PORTS-1:0][IW-1:0]         w_win;
    logic [N_OUT_PORTS-1:0]                 w_gvalid;
    logic [N_OUT_PORTS-1:0][N_IN_PORTS-1:0] w_dgrant;
    logic [N_OUT_PORTS-1:0][IW-1:0]         w_gid;
    logic [N_IN_PORTS-1:0]                  w_grant;

    function automatic int rr_index(input logic [IW-1:0] ptr, input int k);
        return (int'(ptr) + k) % N_IN_PORTS;
    endfunction

    // Starved requesters are promoted one level above every normal priority.
    always_comb begin
        w_starved = '0;
        w_level   = '0;
        for (int i = 0; i < N_IN_PORTS; i++) begin
            w_starved[i] = (r_age[i] == AW'(STARVE_LIMIT));
            w_level[i]   = w_starved[i] ? LW'(N_PRIO_LEVELS) : LW'(req_prio[i]);
        end
    end

    always_comb begin
        w_cand   = '0;
        w_max    = '0;
        w_found  = '0;
        w_win    = '0;
        w_gvalid = '0;
        w_dgrant = '0;
        w_gid    = '0;
        for (int o = 0; o < N_OUT_PORTS; o++) begin
            for (int i = 0; i < N_IN_PORTS; i++) begin
                w_cand[o][i] = req[i] && (req_out_port[i] == OW'(o)) &&
                               (!r_lock[o] || (r_owner[o] == IW'(i)));
                if (w_cand[o][i] && (w_level[i] > w_max[o]))
                    w_max[o] = w_level[i];
            end
            for (int k = 1; k <= N_IN_PORTS; k++) begin
                if (!w_found[o] && w_cand[o][rr_index(r_rr_ptr[o], k)] &&
                    (w_level[rr_index(r_rr_ptr[o], k)] == w_max[o])) begin
                    w_found[o] = 1'b1;
                    w_win[o]   = IW'(rr_index(r_rr_ptr[o], k));
                end
            end
            if (w_found[o] && out_ready[o] && !priority_req[o] && !rst) begin
                w_gvalid[o]           = 1'b1;
                w_dgrant[o][w_win[o]] = 1'b1;
                w_gid[o]              = w_win[o];
            end
        end
    end

    always_comb begin
        w_grant = '0;
        for (int o = 0; o < N_OUT_PORTS; o++)
            w_grant = w_grant | w_dgrant[o];
    end

    assign priority_grant       = rst ? '0 : (priority_req & out_ready);
    assign grant                = w_grant;
    assign detailed_grant       = w_dgrant;
    assign granted_requester_id = w_gid;
    assign locked               = rst ? '0 : r_lock;
    assign starved              = rst ? '0 : w_starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock  <= '0;
            r_owner <= '0;
            r_age   <= '0;
            for (int o = 0; o < N_OUT_PORTS; o++)
                r_rr_ptr[o] <= IW'(N_IN_PORTS - 1);
        end else begin
            for (int o = 0; o < N_OUT_PORTS; o++) begin
                if (w_gvalid[o]) begin
                    r_rr_ptr[o] <= w_win[o];
                    r_owner[o]  <= w_win[o];
                    r_lock[o]   <= !req_last[w_win[o]];
                end
            end
            for (int i = 0; i < N_IN_PORTS; i++) begin
                if (req[i] && !w_grant[i]) begin
                    if (r_age[i] != AW'(STARVE_LIMIT))
                        r_age[i] <= r_age[i] + AW'(1);
                end else begin
                    r_age[i] <= '0;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int o = 0; o < N_OUT_PORTS; o++) begin
                assert ($onehot0(w_dgrant[o]) && !(priority_req[o] && (|w_dgrant[o])))
                    else $warning("crossbar_arbiter_qos: bad grant on output %0d", o);
            end
        end
    end

endmodule

// File: tb/tb_crossbar_arbiter_qos.sv
// Table-driven bench for crossbar_arbiter_qos: each row drives one cycle of
// requests and carries the expected grant/lock/starve/id outputs.
module tb_crossbar_arbiter_qos;
    localparam int NI = 8;
    localparam int NO = 8;
    localparam int W  = 35;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [NI-1:0]         req;
    logic [NI-1:0][2:0]    req_out_port;
    logic [NI-1:0][1:0]    req_prio;
    logic [NI-1:0]         req_last;
    logic [NO-1:0]         out_ready;
    logic [NO-1:0]         priority_req;
    logic [NO-1:0]         priority_grant;
    logic [NI-1:0]         grant;
    logic [NO-1:0][NI-1:0] detailed_grant;
    logic [NO-1:0][2:0]    granted_requester_id;
    logic [NO-1:0]         locked;
    logic [NI-1:0]         starved;

    crossbar_arbiter_qos #(
        .N_IN_PORTS(NI), .N_OUT_PORTS(NO), .N_PRIO_LEVELS(4), .STARVE_LIMIT(15)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_out_port(req_out_port),
        .req_prio(req_prio), .req_last(req_last), .out_ready(out_ready),
        .priority_req(priority_req), .priority_grant(priority_grant),
        .grant(grant), .detailed_grant(detailed_grant),
        .granted_requester_id(granted_requester_id), .locked(locked),
        .starved(starved)
    );

    typedef struct {
        logic        rst_before;
        logic [7:0]  req;
        logic [2:0]  port;
        logic [15:0] prio;
        logic [7:0]  last;
        logic [7:0]  ready;
        logic [7:0]  preq;
        logic [7:0]  e_grant;
        logic [7:0]  e_pgrant;
        logic [7:0]  e_locked;
        logic [7:0]  e_starved;
        logic [2:0]  e_id;
    } vec_t;

    vec_t        vecs[$];
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void add(input logic rb, input logic [7:0] rq, input logic [2:0] pt,
                                input logic [15:0] pr, input logic [7:0] ls, input logic [7:0] rd,
                                input logic [7:0] pq, input logic [7:0] eg, input logic [7:0] epg,
                                input logic [7:0] elk, input logic [7:0] est, input logic [2:0] eid);
        vec_t v;
        v.rst_before = rb; v.req = rq; v.port = pt; v.prio = pr; v.last = ls;
        v.ready = rd; v.preq = pq; v.e_grant = eg; v.e_pgrant = epg;
        v.e_locked = elk; v.e_starved = est; v.e_id = eid;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reset with busy inputs everywhere; every output must stay quiet.
    task automatic do_reset();
        rst = 1'b1;
        req = '1;
        for (int i = 0; i < NI; i++) req_out_port[i] = 3'(i % NO);
        req_prio = '0;
        req_last = '0;
        out_ready = '1;
        priority_req = '1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst grant", 64'(grant), 64'h0);
            check("rst priority_grant", 64'(priority_grant), 64'h0);
            check("rst detailed_grant", 64'(detailed_grant), 64'h0);
            check("rst granted_id", 64'(granted_requester_id), 64'h0);
            check("rst locked", 64'(locked), 64'h0);
            check("rst starved", 64'(starved), 64'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        req = v.req;
        for (int i = 0; i < NI; i++) req_out_port[i] = v.port;
        req_prio = v.prio;
        req_last = v.last;
        out_ready = v.ready;
        priority_req = v.preq;
    endtask

    initial begin
        logic [W-1:0] e;
        rst = 1'b1;
        req = '0; req_out_port = '0; req_prio = '0; req_last = '0;
        out_ready = '0; priority_req = '0;

        // Round-robin from reset: input 0 first, then 3, then 0.
        add(1, 8'h09, 3'd2, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 8'h09, 3'd2, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 3'd3);
        add(0, 8'h09, 3'd2, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0);
        // Priority 3 vs 1; the loser is promoted once its age saturates.
        for (int k = 1; k <= 15; k++)
            add(k == 1, 8'h06, 3'd0, 16'h001C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 3'd1);
        add(0, 8'h06, 3'd0, 16'h001C, 8'hFF, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 3'd2);
        add(0, 8'h06, 3'd0, 16'h001C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 3'd1);
        // Locked transaction on out 5; owner idle cycle keeps the lock.
        add(1, 8'h50, 3'd5, 16'h0, 8'h40, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 3'd4);
        add(0, 8'h40, 3'd5, 16'h0, 8'h40, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 3'd0);
        add(0, 8'h50, 3'd5, 16'h0, 8'h40, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 3'd4);
        add(0, 8'h50, 3'd5, 16'h0, 8'h50, 8'hFF, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 3'd4);
        add(0, 8'h40, 3'd5, 16'h0, 8'h40, 8'hFF, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 3'd6);
        // Side priority request on out 3, with and without out_ready.
        add(1, 8'h01, 3'd3, 16'h0, 8'hFF, 8'hF7, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 3'd0);
        add(0, 8'h01, 3'd3, 16'h0, 8'hFF, 8'hFF, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 3'd0);
        add(0, 8'h01, 3'd3, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0);
        // out_ready[1] low: age climbs and saturates, then the grant lands.
        for (int k = 1; k <= 17; k++)
            add(k == 1, 8'h04, 3'd1, 16'h0, 8'hFF, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h00,
                (k >= 16) ? 8'h04 : 8'h00, 3'd0);
        add(0, 8'h04, 3'd1, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04, 3'd2);
        add(0, 8'h04, 3'd1, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 3'd2);
        // Reset in the middle of a locked transaction on out 0.
        add(1, 8'h20, 3'd0, 16'h0, 8'h00, 8'hFF, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 3'd5);
        add(0, 8'h21, 3'd0, 16'h0, 8'h00, 8'hFF, 8'h00, 8'h20, 8'h00, 8'h01, 8'h00, 3'd5);
        add(1, 8'h21, 3'd0, 16'h0, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0);

        foreach (vecs[n]) begin
            if (vecs[n].rst_before) do_reset();
            drive(vecs[n]);
            exp_q.push_back({vecs[n].e_grant, vecs[n].e_pgrant, vecs[n].e_locked,
                             vecs[n].e_starved, vecs[n].e_id});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("row%0d grant", n), 64'(grant), 64'(e[34:27]));
            check($sformatf("row%0d priority_grant", n), 64'(priority_grant), 64'(e[26:19]));
            check($sformatf("row%0d locked", n), 64'(locked), 64'(e[18:11]));
            check($sformatf("row%0d starved", n), 64'(starved), 64'(e[10:3]));
            check($sformatf("row%0d granted_id", n),
                  64'(granted_requester_id[vecs[n].port]), 64'(e[2:0]));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
